// File: rtl/round_checker_pkg.sv
// rtl/round_checker_pkg.sv - shared types, defaults and helpers for round_checker
//
// Purpose: state encoding, default parameter values and the saturating
// increment used by every counter in the checker.
// Ports: none (package).

package round_checker_pkg;

  localparam int DEF_ADDR_WIDTH    = 12;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_CNT_WIDTH     = 32;
  localparam int DEF_RD_LATENCY    = 1;
  localparam int DEF_SETTLE_CYCLES = 10;
  localparam int DEF_BUSY_WAIT_MAX = 64;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COMPUTE,
    SETTLE,
    CHECK,
    DRAIN,
    DONE
  } state_t;

  // Increment v, holding at the all-ones value of a width-bit counter.
  // Callers widen to 64 bits and truncate the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (v >= max_v) ? v : (v + 64'd1);
  endfunction

endpackage

// File: rtl/round_checker_read_align_pipe.sv
// rtl/round_checker_read_align_pipe.sv - valid/address delay line matching SRAM read latency
//
// Purpose: delays a read-issue strobe and its address by DEPTH cycles so they
// line up with the data returned by a DEPTH-cycle SRAM.
// Ports:
//   clock, reset_b      clock and asynchronous active-low reset
//   valid_in, addr_in   read issued this cycle and its address
//   valid_out, addr_out the same, DEPTH cycles later
//   pending             a read is still travelling (excluding the output stage)

module read_align_pipe #(
  parameter int DEPTH      = 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  valid_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  pending
);

  logic [DEPTH-1:0]      v_sr;
  logic [ADDR_WIDTH-1:0] a_sr [DEPTH];

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      v_sr <= '0;
      for (int i = 0; i < DEPTH; i++) a_sr[i] <= '0;
    end else begin
      v_sr[0] <= valid_in;
      a_sr[0] <= addr_in;
      for (int i = 1; i < DEPTH; i++) begin
        v_sr[i] <= v_sr[i-1];
        a_sr[i] <= a_sr[i-1];
      end
    end
  end

  assign valid_out = v_sr[DEPTH-1];
  assign addr_out  = a_sr[DEPTH-1];

  // The output stage is being consumed this cycle, so only earlier stages
  // mean more compares are still to come.
  generate
    if (DEPTH > 1) begin : g_deep
      assign pending = |v_sr[DEPTH-2:0];
    end else begin : g_shallow
      assign pending = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/round_checker.sv
// rtl/round_checker.sv - accelerator round timer and masked SRAM result checker
//
// Purpose: times the DUT run/busy handshake, then streams result and golden
// SRAMs through a masked comparator and reports counts and first mismatch.
// Ports:
//   clock, reset_b                     clock, asynchronous active-low reset
//   dut_run, dut_busy                  observed DUT handshake
//   num_results, result_base,
//   golden_base, compare_mask          round configuration, latched on run
//   res_read_address/res_read_data     result SRAM read port
//   gold_read_address/gold_read_data   golden SRAM read port
//   check_done, pass, timeout          round status
//   compute_cycles                     measured compute cycles
//   correct_count, mismatch_count      masked compare tallies
//   first_mismatch_valid/_addr         earliest failing result address

module round_checker
  import round_checker_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int RD_LATENCY    = DEF_RD_LATENCY,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int BUSY_WAIT_MAX = DEF_BUSY_WAIT_MAX
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  logic                  dut_run,
  input  logic                  dut_busy,
  input  logic [ADDR_WIDTH:0]   num_results,
  input  logic [ADDR_WIDTH-1:0] result_base,
  input  logic [ADDR_WIDTH-1:0] golden_base,
  input  logic [DATA_WIDTH-1:0] compare_mask,
  output logic [ADDR_WIDTH-1:0] res_read_address,
  input  logic [DATA_WIDTH-1:0] res_read_data,
  output logic [ADDR_WIDTH-1:0] gold_read_address,
  input  logic [DATA_WIDTH-1:0] gold_read_data,
  output logic                  check_done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  compute_cycles,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  first_mismatch_valid,
  output logic [ADDR_WIDTH-1:0] first_mismatch_addr
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_ONE = 1;

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [ADDR_WIDTH-1:0] res_base_q;
  logic [ADDR_WIDTH-1:0] gold_base_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  cycle_cnt_q;
  logic [SETTLE_W-1:0]   settle_cnt_q;

  logic settle_last, last_issue, wait_expired;
  logic start, busy_phase, latch_cycles, check_start, issue, arm_timeout, enter_done;

  logic                  pipe_valid;
  logic                  pipe_pending;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic                  word_match;

  assign settle_last  = (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));
  assign last_issue   = (idx_q == (num_q - NUM_ONE));
  assign wait_expired = (cycle_cnt_q >= CNT_WIDTH'(BUSY_WAIT_MAX));
  assign word_match   = (((res_read_data ^ gold_read_data) & mask_q) == '0);

  // State register
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dut_run) state_d = ARMED;
      ARMED: begin
        if (dut_busy)          state_d = COMPUTE;
        else if (wait_expired) state_d = DONE;
      end
      COMPUTE: if (!dut_busy) state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = (num_q == '0) ? DONE : CHECK;
      CHECK:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (!pipe_pending) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from state
  always_comb begin
    start        = (state_q == IDLE) && dut_run;
    busy_phase   = (state_q == ARMED) || (state_q == COMPUTE);
    latch_cycles = (state_q == COMPUTE) && !dut_busy;
    check_start  = (state_q == SETTLE) && settle_last && (num_q != '0);
    issue        = (state_q == CHECK);
    arm_timeout  = (state_q == ARMED) && !dut_busy && wait_expired;
    enter_done   = (state_d == DONE) && (state_q != DONE);
  end

  // Configuration, cycle counter and settle timer
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      num_q        <= '0;
      res_base_q   <= '0;
      gold_base_q  <= '0;
      mask_q       <= '0;
      cycle_cnt_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      if (start) begin
        num_q       <= num_results;
        res_base_q  <= result_base;
        gold_base_q <= golden_base;
        mask_q      <= compare_mask;
        // The edge that samples run is itself the first counted edge.
        cycle_cnt_q <= CNT_WIDTH'(1);
      end else if (busy_phase) begin
        cycle_cnt_q <= CNT_WIDTH'(sat_inc(64'(cycle_cnt_q), CNT_WIDTH));
      end
      settle_cnt_q <= (state_q == SETTLE) ? settle_cnt_q + SETTLE_W'(1) : '0;
    end
  end

  // Read address generation; addresses wrap naturally at ADDR_WIDTH bits
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      res_read_address  <= '0;
      gold_read_address <= '0;
      idx_q             <= '0;
    end else if (check_start) begin
      res_read_address  <= res_base_q;
      gold_read_address <= gold_base_q;
      idx_q             <= '0;
    end else if (issue) begin
      res_read_address  <= res_read_address + ADDR_WIDTH'(1);
      gold_read_address <= gold_read_address + ADDR_WIDTH'(1);
      idx_q             <= idx_q + NUM_ONE;
    end
  end

  read_align_pipe #(
    .DEPTH      (RD_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_align (
    .clock     (clock),
    .reset_b   (reset_b),
    .valid_in  (issue),
    .addr_in   (res_read_address),
    .valid_out (pipe_valid),
    .addr_out  (pipe_addr),
    .pending   (pipe_pending)
  );

  // Comparator, tallies and round status
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      check_done           <= 1'b0;
      pass                 <= 1'b0;
      timeout              <= 1'b0;
      compute_cycles       <= '0;
      correct_count        <= '0;
      mismatch_count       <= '0;
      first_mismatch_valid <= 1'b0;
      first_mismatch_addr  <= '0;
    end else begin
      check_done <= enter_done;
      if (start) begin
        pass                 <= 1'b0;
        timeout              <= 1'b0;
        compute_cycles       <= '0;
        correct_count        <= '0;
        mismatch_count       <= '0;
        first_mismatch_valid <= 1'b0;
        first_mismatch_addr  <= '0;
      end else begin
        if (latch_cycles) compute_cycles <= cycle_cnt_q;
        if (arm_timeout)  timeout <= 1'b1;
        if (pipe_valid) begin
          if (word_match) begin
            correct_count <= CNT_WIDTH'(sat_inc(64'(correct_count), CNT_WIDTH));
          end else begin
            mismatch_count <= CNT_WIDTH'(sat_inc(64'(mismatch_count), CNT_WIDTH));
            if (!first_mismatch_valid) begin
              first_mismatch_valid <= 1'b1;
              first_mismatch_addr  <= pipe_addr;
            end
          end
        end
        // The final compare lands on the same edge, so fold it in here.
        if (enter_done) begin
          pass <= !arm_timeout && !first_mismatch_valid && !(pipe_valid && !word_match);
        end
      end
    end
  end

endmodule

// File: doc/round_checker.md
# round_checker

Synthesizable round monitor and result checker for the project564 accelerator. It sits beside the DUT and observes the `run`/`busy` handshake to measure compute cycles per round. After the DUT finishes, it streams the output SRAM and a golden-result SRAM through a masked comparator and reports the match count, the mismatch count and the first failing address. It replaces the fixed two-round behavioural collector/timer with a parametrised block that handles any result count, base address, read latency and lane mask, and adds busy-timeout detection.

## Interface
- ADDR_WIDTH, 12, SRAM address width
- DATA_WIDTH, 16, result word width
- CNT_WIDTH, 32, width of the cycle counter and the match counters
- RD_LATENCY, 1, SRAM read latency in cycles (≥1)
- SETTLE_CYCLES, 10, idle cycles between `busy` falling and the first check read
- BUSY_WAIT_MAX, 64, cycles allowed from `run` to `busy` rising before timeout
- clock  in  1  single clock, rising edge
- reset_b  in  1  asynchronous, active-low reset
- dut_run  in  1  observed DUT `run`
- dut_busy  in  1  observed DUT `busy`
- num_results  in  ADDR_WIDTH+1  words to check; latched when `run` rises
- result_base  in  ADDR_WIDTH  first output-SRAM address; latched with `num_results`
- golden_base  in  ADDR_WIDTH  first golden-SRAM address; latched with `num_results`
- compare_mask  in  DATA_WIDTH  a 1 bit is compared; latched with `num_results`
- res_read_address  out  ADDR_WIDTH  output-SRAM read address
- res_read_data  in  DATA_WIDTH  output-SRAM read data
- gold_read_address  out  ADDR_WIDTH  golden-SRAM read address
- gold_read_data  in  DATA_WIDTH  golden-SRAM read data
- check_done  out  1  one-cycle pulse when the round's results are final
- pass  out  1  no mismatches and no timeout; valid from `check_done`
- timeout  out  1  `busy` never rose within BUSY_WAIT_MAX
- compute_cycles  out  CNT_WIDTH  measured compute cycles
- correct_count  out  CNT_WIDTH  masked matches
- mismatch_count  out  CNT_WIDTH  masked mismatches
- first_mismatch_valid  out  1  a mismatch was seen this round
- first_mismatch_addr  out  ADDR_WIDTH  result-SRAM address of the first mismatch

## Operation
- States:
  - IDLE → ARMED: when `dut_run` is sampled 1. Latch all config inputs, clear all result outputs, set cycle counter to 1.
  - ARMED → COMPUTE: when `dut_busy` is sampled 1.
  - ARMED → DONE: when the counter reaches BUSY_WAIT_MAX. Sets `timeout`; no reads are issued.
  - COMPUTE → SETTLE: when `dut_busy` is sampled 0. Latch `compute_cycles`.
  - SETTLE → CHECK: after SETTLE_CYCLES cycles.
  - CHECK → DRAIN: after the last address is issued.
  - DRAIN → DONE: when the compare pipeline is empty.
  - DONE → IDLE: after one cycle.
- Cycle counter: increments every cycle in ARMED and COMPUTE and saturates at all-ones.
- CHECK reads: issue one read per cycle on both SRAMs at `base + i`, for i = 0..num_results−1.
- Address arithmetic: modulo 2^ADDR_WIDTH, so reads wrap to 0.
- Compare pipeline: valid and address are delayed RD_LATENCY stages to align with returning data. A match is `((res ^ gold) & mask) == 0`.
- Match counters: `correct_count` or `mismatch_count` increments per compared word; both saturate.
- First mismatch: `first_mismatch_addr` captures the result address of the earliest mismatch only.
- `num_results = 0`: skip CHECK and DRAIN, going SETTLE → DONE. Counts are 0 and `pass` = 1.
- `compare_mask = 0`: every word counts as correct.
- `dut_run` toggling outside IDLE is ignored.
- A `busy` glitch back to 1 during SETTLE is ignored.
- Result outputs hold their values from `check_done` until the next IDLE → ARMED transition.

## Timing
- Reset (async, `reset_b` = 0): state IDLE; every output 0, including the read addresses.
- Reset mid-round: the round aborts immediately and no `check_done` is produced.
- `compute_cycles` = number of rising edges from the edge sampling `run` = 1 through the edge sampling `busy` = 0, inclusive of the first and exclusive of the last.
- Check phase: N words take N + RD_LATENCY cycles from the first CHECK cycle to DONE.
- `check_done` is asserted in DONE, the cycle after the final compare is registered.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `round_checker_pkg`:
  - state enum (IDLE, ARMED, COMPUTE, SETTLE, CHECK, DRAIN, DONE)
  - saturating-increment function
  - default parameter constants
- Sub-module `read_align_pipe`: a RD_LATENCY-deep shift register carrying valid and address. It is reused for any future multi-port checker.
- The comparator and counters stay in the top module.

## Test plan
- Nominal round: DUT model raises `busy` 3 cycles after `run`, holds it 200 cycles; N = 96; all words match. Required: `compute_cycles` = 203, `correct_count` = 96, `pass` = 1.
- Mismatch round: N = 144, with words at 0x010, 0x020 and 0x08f corrupted. Required: `mismatch_count` = 3, `correct_count` = 141, `first_mismatch_addr` = 0x010, `pass` = 0.
- Lane mask: `compare_mask` = 0x00FF, and word 5 differs only in bits 15:8. Required: `correct_count` = N and `pass` = 1. Repeat with mask 0xFFFF: `mismatch_count` = 1.
- Boundaries:
  - N = 0: `check_done` occurs SETTLE_CYCLES + 1 cycles after `busy` falls, with `pass` = 1.
  - `result_base` = 0xFFE, N = 4: addresses issued are 0xFFE, 0xFFF, 0x000, 0x001.
  - `busy` never rises: `timeout` = 1 and `check_done` occurs BUSY_WAIT_MAX cycles after `run`, with no reads issued.
- Reset mid-CHECK after 50 reads: all outputs are 0 immediately. The next round runs normally with fresh counts.
- RD_LATENCY = 3: the nominal and mismatch scenarios give identical counts, and DONE arrives 2 cycles later.
